pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller.sv | 158 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/freeze controller with memory-wait timeout and
// saturating performance counters. Control outputs are combinational from
// state and current inputs so the datapath sees them in the same cycle.
module pipeline_stall_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_counters,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count,
  output logic             mem_fault
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze_c;
  logic              inc_stall, inc_flush, inc_freeze;

  // Memory not ready for an outstanding access; mem_ready alone is ignored
  assign freeze_c  = mem_req && !mem_ready;
  assign mem_fault = (state == FAULT);

  // State register and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state, priority-resolved pipeline controls and counter increments
  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    inc_stall    = 1'b0;
    inc_flush    = 1'b0;
    inc_freeze   = 1'b0;

    case (state)
      RUN: begin
        if (freeze_c) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze_c) begin
          if (wait_cnt == WAIT_LIMIT) begin
            state_nxt = FAULT;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase

    if (state == FAULT) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (freeze_c) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      inc_freeze   = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      inc_flush   = 1'b1;
    end else if (hz_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      inc_stall   = 1'b1;
    end

    // Reset forces idle controls immediately, without waiting for a clock
    if (!rst_n) begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count  <= '0;
      flush_count  <= '0;
      freeze_count <= '0;
    end else if (clr_counters) begin
      stall_count  <= '0;
      flush_count  <= '0;
      freeze_count <= '0;
    end else begin
      if (inc_stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_W'(1);
      if (inc_flush && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_W'(1);
      if (inc_freeze && (freeze_count != CNT_MAX))
        freeze_count <= freeze_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (CNT_W=4, MEM_TIMEOUT=4).
// Expected control vectors are queued as stimulus is driven and popped when
// the combinational outputs are sampled mid-cycle.
module tb_pipeline_stall_controller;

  localparam int unsigned CW = 4;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble, mem_fault}
  localparam logic [7:0] E_DEF   = 8'b1100_1100;
  localparam logic [7:0] E_STALL = 8'b0001_1100;
  localparam logic [7:0] E_FLUSH = 8'b1111_1100;
  localparam logic [7:0] E_FRZ   = 8'b0000_0010;
  localparam logic [7:0] E_FAULT = 8'b0000_0011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hz_stall, branch_taken, mem_req, mem_ready, clr_counters;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble;
  logic          idex_write, exmem_write, memwb_bubble, mem_fault;
  logic [CW-1:0] stall_count, flush_count, freeze_count;

  logic [7:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  pipeline_stall_controller #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_counters(clr_counters),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_write(idex_write), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .stall_count(stall_count), .flush_count(flush_count),
    .freeze_count(freeze_count), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // Pop the oldest expected vector and compare against the live outputs
  task automatic check_ctrl(input string tag);
    logic [7:0] obs, exp;
    obs = {pc_write, ifid_write, ifid_flush, idex_bubble,
           idex_write, exmem_write, memwb_bubble, mem_fault};
    exp = exp_q.pop_front();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check controls
  task automatic step(input logic hz, input logic br, input logic rq, input logic rd,
                      input logic clr, input logic [7:0] exp, input string tag);
    @(negedge clk);
    hz_stall = hz; branch_taken = br; mem_req = rq; mem_ready = rd; clr_counters = clr;
    exp_q.push_back(exp);
    #2;
    check_ctrl(tag);
  endtask

  task automatic cmp_cnt(input logic [CW-1:0] s, input logic [CW-1:0] f,
                         input logic [CW-1:0] z, input string tag);
    logic [3*CW-1:0] obs, exp;
    obs = {stall_count, flush_count, freeze_count};
    exp = {s, f, z};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed stall/flush/freeze %h expected %h", tag, obs, exp);
    end
  endtask

  // Counters after the upcoming rising edge
  task automatic chk_cnt(input logic [CW-1:0] s, input logic [CW-1:0] f,
                         input logic [CW-1:0] z, input string tag);
    @(posedge clk);
    #1;
    cmp_cnt(s, f, z, tag);
  endtask

  // Assert reset between edges with current inputs held, then release idle
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(E_DEF);
    check_ctrl(tag);
    cmp_cnt('0, '0, '0, tag);
    @(negedge clk);
    hz_stall = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; clr_counters = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    hz_stall = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; clr_counters = 0;
    #3;
    exp_q.push_back(E_DEF);
    check_ctrl("reset_ctrl");
    cmp_cnt('0, '0, '0, "reset_cnt");
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use stall
    step(1, 0, 0, 0, 0, E_STALL, "hz_stall");
    chk_cnt(1, 0, 0, "stall_cnt");
    step(0, 0, 0, 0, 0, E_DEF, "idle1");

    // Branch squashes a simultaneous stall
    step(1, 1, 0, 0, 0, E_FLUSH, "branch_over_stall");
    chk_cnt(1, 1, 0, "flush_cnt");

    // Freeze beats branch for three cycles, then the branch flushes
    step(0, 1, 1, 0, 0, E_FRZ, "freeze1");
    step(0, 1, 1, 0, 0, E_FRZ, "freeze2");
    step(0, 1, 1, 0, 0, E_FRZ, "freeze3");
    step(0, 1, 1, 1, 0, E_FLUSH, "freeze_release");
    chk_cnt(1, 2, 3, "freeze_cnt");
    step(0, 0, 0, 1, 0, E_DEF, "ready_without_req");

    // Clear counters
    step(0, 0, 0, 0, 1, E_DEF, "clear");
    chk_cnt(0, 0, 0, "clear_cnt");

    // Saturation of a 4-bit counter, then clear overriding increment
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, E_STALL, "stall_hold");
    chk_cnt(15, 0, 0, "stall_sat");
    step(1, 0, 0, 0, 1, E_STALL, "clr_with_stall");
    chk_cnt(0, 0, 0, "clr_over_inc");

    // Reset in the middle of a memory wait with freeze inputs held
    step(0, 0, 1, 0, 0, E_FRZ, "wait_a");
    step(0, 0, 1, 0, 0, E_FRZ, "wait_b");
    pulse_reset("reset_mid_wait");

    // Timeout: fault only after the fourth cycle spent in MEM_WAIT
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, E_FRZ, "pre_timeout");
    step(0, 0, 0, 0, 0, E_FAULT, "fault_sticky");
    step(1, 1, 1, 1, 0, E_FAULT, "fault_ignores_inputs");
    chk_cnt(0, 0, 5, "fault_no_count");
    pulse_reset("reset_from_fault");
    step(0, 0, 0, 0, 0, E_DEF, "after_fault_idle");
    step(1, 0, 0, 0, 0, E_STALL, "after_fault_stall");
    chk_cnt(1, 0, 0, "after_fault_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
